// File: rtl/const_rom_fetch_if.sv
// Request/response bus between the hash core (master) and the constant ROM
// fetch sequencer (slave). STREAM exists only when CONST_FETCH_STREAM_EN is
// defined.
interface const_rom_fetch_if;
  logic        REQ;
  logic        SEL;
  logic [5:0]  IDX;
`ifdef CONST_FETCH_STREAM_EN
  logic        STREAM;
`endif
  logic        BUSY;
  logic        VALID;
  logic [31:0] DATA;

`ifdef CONST_FETCH_STREAM_EN
  modport master (output REQ, SEL, IDX, STREAM, input BUSY, VALID, DATA);
  modport slave  (input REQ, SEL, IDX, STREAM, output BUSY, VALID, DATA);
`else
  modport master (output REQ, SEL, IDX, input BUSY, VALID, DATA);
  modport slave  (input REQ, SEL, IDX, output BUSY, VALID, DATA);
`endif
endinterface

// File: rtl/const_rom_fetch.sv
// const_rom_fetch: sequences the four byte-lane EEPROMs holding the SHA-256
// constants (H0..H7, K0..K63) and returns one assembled 32-bit word per
// request. Optional macro CONST_FETCH_STREAM_EN adds back-to-back streaming
// of consecutive words up to the end of the selected table.
module const_rom_fetch #(
  parameter int ADDR_W      = 13,
  parameter int WAIT_CYCLES = 3,
  parameter int H_BASE      = 0,
  parameter int K_BASE      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  const_rom_fetch_if.slave  bus,
  output logic [ADDR_W-1:0] ROM_A,
  output logic              ROM_CE,
  output logic              ROM_OE,
  output logic              ROM_WE,
  input  logic [7:0]        IO_1,
  input  logic [7:0]        IO_2,
  input  logic [7:0]        IO_3,
  input  logic [7:0]        IO_4
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;
  logic              rom_ce_q, rom_ce_d;
  logic              rom_oe_q, rom_oe_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] req_addr;
`ifdef CONST_FETCH_STREAM_EN
  logic              stream_q, stream_d;
  logic [ADDR_W-1:0] last_a_q, last_a_d;
  logic [ADDR_W-1:0] req_last;
`endif

  // Table address of the requested word; H index wraps modulo 8.
  always_comb begin
    req_addr = bus.SEL ? (ADDR_W'(K_BASE) + ADDR_W'(bus.IDX))
                       : (ADDR_W'(H_BASE) + ADDR_W'(bus.IDX[2:0]));
`ifdef CONST_FETCH_STREAM_EN
    req_last = bus.SEL ? ADDR_W'(K_BASE + 63) : ADDR_W'(H_BASE + 7);
`endif
  end

  // Next-state and registered-output logic of the fetch sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rom_a_d  = rom_a_q;
    rom_ce_d = rom_ce_q;
    rom_oe_d = rom_oe_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
`ifdef CONST_FETCH_STREAM_EN
    stream_d = stream_q;
    last_a_d = last_a_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          state_d = S_SETUP;
          rom_a_d = req_addr;   // address only moves while the chips are off
          busy_d  = 1'b1;
`ifdef CONST_FETCH_STREAM_EN
          stream_d = bus.STREAM;
          last_a_d = req_last;
`endif
        end
      end
      S_SETUP: begin
        state_d  = S_ACCESS;
        cnt_d    = CNT_INIT;
        rom_ce_d = 1'b0;
        rom_oe_d = 1'b0;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_DONE;
          data_d   = {IO_1, IO_2, IO_3, IO_4};
          rom_ce_d = 1'b1;
          rom_oe_d = 1'b1;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
`ifdef CONST_FETCH_STREAM_EN
        if (stream_q && (rom_a_q != last_a_q)) begin
          state_d = S_SETUP;
          rom_a_d = rom_a_q + ADDR_W'(1);
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset drops the chips and aborts any fetch in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rom_a_q  <= '0;
      rom_ce_q <= 1'b1;
      rom_oe_q <= 1'b1;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CONST_FETCH_STREAM_EN
      stream_q <= 1'b0;
      last_a_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rom_a_q  <= rom_a_d;
      rom_ce_q <= rom_ce_d;
      rom_oe_q <= rom_oe_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef CONST_FETCH_STREAM_EN
      stream_q <= stream_d;
      last_a_q <= last_a_d;
`endif
    end
  end

  assign ROM_A     = rom_a_q;
  assign ROM_CE    = rom_ce_q;
  assign ROM_OE    = rom_oe_q;
  assign ROM_WE    = 1'b1;
  assign bus.DATA  = data_q;
  assign bus.VALID = valid_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_const_rom_fetch.sv
// Bench for const_rom_fetch: EEPROM behavioural model plus directed and
// randomized fetches checked against the SHA-256 constant table.
module tb_const_rom_fetch;
  localparam int ADDR_W = 13;
  localparam int W      = 3;
  localparam int HB     = 0;
  localparam int KB     = 8;

  localparam logic [31:0] ROM_IMG [72] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rom_a;
  logic              rom_ce, rom_oe, rom_we;
  logic [7:0]        io1, io2, io3, io4;
  logic [31:0]       noise = 32'h0;
  logic [31:0]       rom_word;
  int                checks = 0;
  int                errors = 0;

  const_rom_fetch_if bus ();

  const_rom_fetch #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W), .H_BASE(HB), .K_BASE(KB)) dut (
    .CLK(clk), .RST(rst), .bus(bus),
    .ROM_A(rom_a), .ROM_CE(rom_ce), .ROM_OE(rom_oe), .ROM_WE(rom_we),
    .IO_1(io1), .IO_2(io2), .IO_3(io3), .IO_4(io4)
  );

  always #5 clk = ~clk;

  // EEPROM model: real data only while both enables are low, junk otherwise.
  always @(negedge clk) noise <= $urandom;
  always_comb begin
    rom_word = (int'(rom_a) < 72) ? ROM_IMG[rom_a] : 32'hdeadbeef;
    if (!rom_ce && !rom_oe) {io1, io2, io3, io4} = rom_word;
    else                    {io1, io2, io3, io4} = noise;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; returns the last word delivered. Expected address and data
  // come from the table rules, not from the DUT.
  task automatic do_fetch(input logic sel, input logic [5:0] idx, input bit hold_req,
                          input bit strm, output logic [31:0] last_data);
    int ea, last, nwords, n, ce_low;
    ea     = sel ? KB + int'(idx) : HB + int'(idx % 6'd8);
    last   = sel ? KB + 63 : HB + 7;
    nwords = strm ? (last - ea + 1) : 1;
    last_data = 32'h0;
    @(negedge clk);
    bus.REQ = 1'b1; bus.SEL = sel; bus.IDX = idx;
`ifdef CONST_FETCH_STREAM_EN
    bus.STREAM = strm;
`endif
    @(negedge clk);
    chk("accept_addr", 32'(rom_a), 32'(ea));
    chk("accept_busy", 32'(bus.BUSY), 32'd1);
    if (!hold_req) bus.REQ = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      n = (w == 0) ? 1 : 0;
      ce_low = 0;
      do begin
        @(negedge clk);
        n++;
        if (rom_ce === 1'b0) begin
          ce_low++;
          chk("addr_stable", 32'(rom_a), 32'(ea));
        end
        chk("we_high", 32'(rom_we), 32'd1);
      end while (!bus.VALID && n < 30);
      chk("latency", 32'(n), 32'(W + 2));
      chk("ce_low_cycles", 32'(ce_low), 32'(W));
      chk("data", bus.DATA, ROM_IMG[ea]);
      chk("done_busy", 32'(bus.BUSY), 32'd1);
      last_data = bus.DATA;
      ea++;
    end
    @(negedge clk);
    bus.REQ = 1'b0;
    chk("idle_busy", 32'(bus.BUSY), 32'd0);
    chk("idle_valid", 32'(bus.VALID), 32'd0);
    chk("idle_ce", 32'(rom_ce), 32'd1);
    if (hold_req) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("ignored_req_valid", 32'(bus.VALID), 32'd0);
        chk("ignored_req_busy", 32'(bus.BUSY), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    bus.REQ = 1'b0; bus.SEL = 1'b0; bus.IDX = 6'd0;
`ifdef CONST_FETCH_STREAM_EN
    bus.STREAM = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ce", 32'(rom_ce), 32'd1);
    chk("rst_oe", 32'(rom_oe), 32'd1);
    chk("rst_we", 32'(rom_we), 32'd1);
    chk("rst_valid", 32'(bus.VALID), 32'd0);
    chk("rst_data", bus.DATA, 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_addr", 32'(rom_a), 32'd0);
    rst = 1'b0;

    do_fetch(1'b0, 6'd0, 1'b0, 1'b0, d);  chk("h0_word", d, 32'h6a09e667);
    do_fetch(1'b1, 6'd0, 1'b0, 1'b0, d);  chk("k0_word", d, 32'h428a2f98);
    do_fetch(1'b1, 6'd63, 1'b0, 1'b0, d); chk("k63_word", d, 32'hc67178f2);
    do_fetch(1'b0, 6'd9, 1'b1, 1'b0, d);  chk("h_wrap_word", d, 32'hbb67ae85);

    // Reset during ACCESS: fetch aborted, chips released, no VALID.
    @(negedge clk);
    bus.REQ = 1'b1; bus.SEL = 1'b1; bus.IDX = 6'd5;
    @(negedge clk);
    bus.REQ = 1'b0;
    @(negedge clk);
    chk("abort_in_access_ce", 32'(rom_ce), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ce", 32'(rom_ce), 32'd1);
    chk("abort_oe", 32'(rom_oe), 32'd1);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_valid", 32'(bus.VALID), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.VALID), 32'd0);
    end
    do_fetch(1'b0, 6'd0, 1'b0, 1'b0, d);  chk("h0_after_abort", d, 32'h6a09e667);

    repeat (12) begin
      do_fetch(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef CONST_FETCH_STREAM_EN
    do_fetch(1'b1, 6'd61, 1'b0, 1'b1, d); chk("stream_k_last", d, 32'hc67178f2);
    do_fetch(1'b0, 6'd13, 1'b0, 1'b1, d); chk("stream_h_last", d, 32'h5be0cd19);
    do_fetch(1'b1, 6'd63, 1'b0, 1'b1, d); chk("stream_single", d, 32'hc67178f2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
